// File: rtl/mem_port_if.sv
// mem_port_if: instruction-fetch and load/store request ports plus the RAM macro port
// of the shared data-RAM arbiter; slave is the arbiter side, master the requesters and RAM.
interface mem_port_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;
    logic              ram_en;
    logic              ram_we;
    logic [7:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               ram_en, ram_we, ram_be, ram_addr, ram_wdata, busy
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               ram_en, ram_we, ram_be, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported data RAM between instruction fetch and load/store,
// running one access at a time and returning aligned read data or store acks to the winner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic       clk_sys_i,
    input logic       rst_sys_i,
    mem_port_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = RAM_LAT > 1 ? $clog2(RAM_LAT) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state, state_nxt;
    logic [SW-1:0]     starve;
    logic [LW-1:0]     lat_cnt;
    logic              owner_ls, we_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, ls_rdata_q, size_mask, ls_shifted;
    logic [31:0]       if_rdata_q;
    logic [7:0]        lanes;
    logic              ls_win, ls_mis, lat_done;
    // IF is forced through only once it has lost STARVE_MAX arbitrations in a row
    assign ls_win   = bus.ls_req && !(bus.if_req && starve == SW'(STARVE_MAX));
    assign ls_mis   = |(bus.ls_addr[2:0] & ((3'd1 << bus.ls_size) - 3'd1));
    assign lat_done = lat_cnt == LW'(RAM_LAT - 1);
    always_comb begin
        state_nxt     = state;
        bus.if_gnt    = 1'b0;
        bus.ls_gnt    = 1'b0;
        bus.ram_en    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.ls_rvalid = 1'b0;
        case (state)
            IDLE: begin
                bus.ls_gnt = ls_win;
                bus.if_gnt = bus.if_req && !ls_win;
                state_nxt  = ls_win ? (ls_mis ? RESP : ACCESS) : bus.if_req ? ACCESS : IDLE;
            end
            ACCESS: begin
                bus.ram_en = 1'b1;
                state_nxt  = lat_done ? RESP : ACCESS;
            end
            RESP: begin
                bus.ls_rvalid = owner_ls;
                bus.if_rvalid = !owner_ls;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys_i or posedge rst_sys_i)
        if (rst_sys_i) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk_sys_i or posedge rst_sys_i)
        if (rst_sys_i) begin
            starve     <= '0;
            lat_cnt    <= '0;
            owner_ls   <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ls_rdata_q <= '0;
            if_rdata_q <= '0;
        end else begin
            starve  <= !bus.if_req || bus.if_gnt ? '0 :
                       bus.ls_gnt && starve != SW'(STARVE_MAX) ? starve + 1'b1 : starve;
            lat_cnt <= state == ACCESS && !lat_done ? lat_cnt + 1'b1 : '0;
            if (bus.ls_gnt || bus.if_gnt) begin
                owner_ls <= bus.ls_gnt;
                we_q     <= bus.ls_gnt && bus.ls_we;
                err_q    <= bus.ls_gnt && ls_mis;
                size_q   <= bus.ls_gnt ? bus.ls_size : 2'd2;
                addr_q   <= bus.ls_gnt ? bus.ls_addr : bus.if_addr;
                wdata_q  <= bus.ls_wdata;
                if (bus.ls_gnt && ls_mis) ls_rdata_q <= '0;
            end
            if (state == ACCESS && lat_done) begin
                if (!owner_ls) if_rdata_q <= addr_q[2] ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];
                else if (!we_q) ls_rdata_q <= ls_shifted & size_mask;
            end
        end
    // shifting all-ones by 64 for a doubleword leaves nothing, so the mask becomes all ones
    assign size_mask     = ~({DATA_W{1'b1}} << (7'd8 << size_q));
    assign ls_shifted    = bus.ram_rdata >> {addr_q[2:0], 3'b000};
    assign lanes         = 8'((9'd1 << (4'd1 << size_q)) - 9'd1);
    assign bus.ram_be    = !bus.ram_en ? 8'h00 : owner_ls ? lanes << addr_q[2:0] : 8'hFF;
    assign bus.ram_we    = bus.ram_en && we_q;
    assign bus.ram_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign bus.ram_wdata = wdata_q << {addr_q[2:0], 3'b000};
    assign bus.ls_err    = bus.ls_rvalid && err_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: fixed vectors, arbitration/starvation/reset sequences and random traffic,
// all judged against a byte-array model of memory contents.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 64, DATA_W = 64, RAM_LAT = 1, STARVE_MAX = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX))
        dut (.clk_sys_i(clk), .rst_sys_i(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [63:0] ram [0:63];
    byte unsigned ref_mem [0:511];
    assign bus.ram_rdata = ram[bus.ram_addr[8:3]];
    always @(posedge clk)
        if (bus.ram_en && bus.ram_we)
            for (int i = 0; i < 8; i++)
                if (bus.ram_be[i]) ram[bus.ram_addr[8:3]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
    logic [63:0] last_ls, last_if;
    bit ls_known = 0, if_known = 0;
    typedef struct {
        bit ls; bit we; logic [1:0] sz; logic [63:0] addr; logic [63:0] wd;
        logic [63:0] exp_rd; logic [7:0] exp_be; bit exp_err;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_rd(input logic [8:0] a, input int nb);
        ref_rd = '0;
        for (int i = 0; i < nb; i++) ref_rd[8*i +: 8] = ref_mem[a + 9'(i)];
    endfunction

    task automatic wait_idle();
        for (int n = 0; n < 20 && bus.busy; n++) @(negedge clk);
        check("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic xact(input bit ls, input bit we, input logic [1:0] sz, input logic [63:0] addr,
                        input logic [63:0] wd, output bit gnt, output int en_n, output int rv_n,
                        output logic [7:0] be, output logic rwe, output logic [63:0] raddr,
                        output logic [63:0] rwd, output logic [63:0] rd, output logic err);
        @(negedge clk);
        bus.if_req = !ls; bus.if_addr = addr;
        bus.ls_req = ls; bus.ls_we = we; bus.ls_size = sz; bus.ls_addr = addr; bus.ls_wdata = wd;
        #1 gnt = ls ? bus.ls_gnt : bus.if_gnt;
        @(negedge clk);
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        en_n = 0; rv_n = -1; be = '0; rwe = 1'b0; raddr = '0; rwd = '0; rd = '0; err = 1'b0;
        for (int n = 0; n < RAM_LAT + 4 && rv_n < 0; n++) begin
            if (bus.ram_en) begin
                en_n++; be = bus.ram_be; rwe = bus.ram_we; raddr = bus.ram_addr; rwd = bus.ram_wdata;
            end
            if (bus.ls_rvalid || bus.if_rvalid) begin
                rv_n = n; rd = ls ? bus.ls_rdata : 64'(bus.if_rdata); err = bus.ls_err;
            end else @(negedge clk);
        end
    endtask

    task automatic run_ref(input bit ls, input bit we, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wd, output logic [7:0] be, output logic [63:0] rd,
                           output logic err);
        bit gnt, mis, wr;
        int en_n, rv_n, nb, a0;
        logic rwe;
        logic [63:0] raddr, rwd, exp_rd, exp_w, lane_m;
        logic [7:0] exp_be;
        nb = ls ? (1 << sz) : 4;
        a0 = int'(addr[2:0]);
        mis = ls && (a0 % nb != 0);
        wr = ls && we && !mis;
        exp_be = ls ? 8'h00 : 8'hFF; exp_w = '0; lane_m = '0;
        exp_rd = mis ? 64'd0 : ref_rd(addr[8:0], nb);
        if (!mis)
            for (int i = 0; i < nb; i++) begin
                if (ls) exp_be[a0 + i] = 1'b1;
                exp_w[8*(a0 + i) +: 8] = wd[8*i +: 8];
                lane_m[8*(a0 + i) +: 8] = 8'hFF;
            end
        if (if_known) check("if_rdata_hold", 64'(bus.if_rdata), last_if);
        if (ls_known) check("ls_rdata_hold", bus.ls_rdata, last_ls);
        xact(ls, we, sz, addr, wd, gnt, en_n, rv_n, be, rwe, raddr, rwd, rd, err);
        check("gnt", 64'(gnt), 64'd1);
        check("en_cycles", 64'(en_n), mis ? 64'd0 : 64'(RAM_LAT));
        check("rvalid_lat", 64'(rv_n), mis ? 64'd0 : 64'(RAM_LAT));
        check("ls_err", 64'(err), 64'(mis));
        if (!mis) begin
            check("ram_addr", raddr, {addr[63:3], 3'b000});
            check("ram_be", 64'(be), 64'(exp_be));
            check("ram_we", 64'(rwe), 64'(wr));
        end
        if (wr) begin
            check("ram_wdata", rwd & lane_m, exp_w);
            for (int i = 0; i < nb; i++) ref_mem[addr[8:0] + 9'(i)] = wd[8*i +: 8];
            ls_known = 0;
        end else begin
            check(ls ? "ls_rdata" : "if_rdata", rd, exp_rd);
            if (ls) begin last_ls = exp_rd; ls_known = 1; end
            else begin last_if = exp_rd; if_known = 1; end
        end
        @(negedge clk);
        check("rvalid_pulse", 64'(bus.ls_rvalid | bus.if_rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] be;
        logic [63:0] rd, addr;
        logic err;
        bit ls, we;
        logic [1:0] sz;
        int first_if, ls_rv, if_rv, s, wins, rv;
        bit exp_if;
        bus.if_req = 0; bus.if_addr = '0; bus.ls_req = 0; bus.ls_we = 0;
        bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        for (int w = 0; w < 64; w++) begin
            ram[w] = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) ref_mem[8*w + b] = ram[w][8*b +: 8];
        end
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ram_en", 64'(bus.ram_en), 64'd0);
        check("rst_gnt", 64'({bus.if_gnt, bus.ls_gnt}), 64'd0);
        check("rst_rvalid", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
        check("rst_ls_rdata", bus.ls_rdata, 64'd0);
        check("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
        rst = 1'b0;
        last_ls = '0; last_if = '0; ls_known = 1; if_known = 1;
        // ls, we, size, addr, wdata, expected rdata, expected be, expected err
        tbl.push_back('{1, 1, 2'd3, 64'h8100, 64'h1234_5678_9ABC_DEF0, 64'h0, 8'hFF, 0});
        tbl.push_back('{1, 1, 2'd0, 64'h8103, 64'hAB, 64'h0, 8'h08, 0});
        tbl.push_back('{1, 0, 2'd3, 64'h8100, 64'h0, 64'h1234_5678_ABBC_DEF0, 8'hFF, 0});
        tbl.push_back('{1, 0, 2'd1, 64'h8106, 64'h0, 64'h1234, 8'hC0, 0});
        tbl.push_back('{1, 0, 2'd0, 64'h8103, 64'h0, 64'hAB, 8'h08, 0});
        tbl.push_back('{1, 0, 2'd2, 64'h8104, 64'h0, 64'h1234_5678, 8'hF0, 0});
        tbl.push_back('{1, 1, 2'd2, 64'h8108, 64'hCAFE_F00D, 64'h0, 8'h0F, 0});
        tbl.push_back('{1, 1, 2'd1, 64'h810A, 64'hFFFF_BEEF, 64'h0, 8'h0C, 0});
        tbl.push_back('{1, 0, 2'd2, 64'h8108, 64'h0, 64'hBEEF_F00D, 8'h0F, 0});
        tbl.push_back('{1, 1, 2'd2, 64'h8102, 64'h5555, 64'h0, 8'h00, 1});
        tbl.push_back('{1, 0, 2'd3, 64'h8104, 64'h0, 64'h0, 8'h00, 1});
        tbl.push_back('{1, 0, 2'd1, 64'h8101, 64'h0, 64'h0, 8'h00, 1});
        tbl.push_back('{0, 0, 2'd2, 64'h8104, 64'h0, 64'h1234_5678, 8'hFF, 0});
        tbl.push_back('{0, 0, 2'd2, 64'h8108, 64'h0, 64'hBEEF_F00D, 8'hFF, 0});
        tbl.push_back('{1, 1, 2'd3, 64'h8400, 64'h1111_2222_3333_4444, 64'h0, 8'hFF, 0});
        tbl.push_back('{0, 0, 2'd2, 64'h8404, 64'h0, 64'h1111_2222, 8'hFF, 0});
        foreach (tbl[k]) begin
            run_ref(tbl[k].ls, tbl[k].we, tbl[k].sz, tbl[k].addr, tbl[k].wd, be, rd, err);
            check("tbl_err", 64'(err), 64'(tbl[k].exp_err));
            if (!tbl[k].exp_err) check("tbl_be", 64'(be), 64'(tbl[k].exp_be));
            if (!(tbl[k].ls && tbl[k].we) || tbl[k].exp_err) check("tbl_rdata", rd, tbl[k].exp_rd);
        end
        // simultaneous IF and LS: LS first, IF granted at the next IDLE, both served
        wait_idle();
        @(negedge clk);
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'd3; bus.ls_addr = 64'h8100;
        bus.if_req = 1; bus.if_addr = 64'h8104;
        #1 check("both_gnt", 64'({bus.ls_gnt, bus.if_gnt}), 64'b10);
        first_if = -1; ls_rv = 0; if_rv = 0;
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            if (c == 1) bus.ls_req = 0;
            if (first_if >= 0 && c == first_if + 1) bus.if_req = 0;
            #1;
            ls_rv += int'(bus.ls_rvalid);
            if_rv += int'(bus.if_rvalid);
            if (bus.if_gnt && first_if < 0) first_if = c;
        end
        check("if_gnt_delay", 64'(first_if), 64'd3);
        check("both_ls_rvalid", 64'(ls_rv), 64'd1);
        check("both_if_rvalid", 64'(if_rv), 64'd1);
        check("both_ls_rdata", bus.ls_rdata, ref_rd(9'h100, 8));
        check("both_if_rdata", 64'(bus.if_rdata), ref_rd(9'h104, 4));
        last_ls = ref_rd(9'h100, 8); last_if = ref_rd(9'h104, 4);
        // both held: STARVE_MAX LS wins, then one IF win, and the pattern repeats
        wait_idle();
        @(negedge clk);
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'd3; bus.ls_addr = 64'h8108;
        bus.if_req = 1; bus.if_addr = 64'h810C;
        s = 0; wins = 0;
        for (int c = 0; c < 80 && wins < 10; c++) begin
            #1;
            if (bus.ls_gnt || bus.if_gnt) begin
                exp_if = s == STARVE_MAX;
                check("starve_winner", 64'({bus.ls_gnt, bus.if_gnt}), 64'({!exp_if, exp_if}));
                s = exp_if ? 0 : s + 1;
                wins++;
            end
            @(negedge clk);
        end
        check("starve_grants", 64'(wins), 64'd10);
        bus.ls_req = 0; bus.if_req = 0;
        wait_idle();
        last_ls = ref_rd(9'h108, 8); last_if = ref_rd(9'h10C, 4);
        check("starve_ls_rdata", bus.ls_rdata, last_ls);
        check("starve_if_rdata", 64'(bus.if_rdata), last_if);
        // reset in the middle of an access aborts it with no response
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = 64'h8110;
        @(negedge clk);
        bus.if_req = 0;
        check("abort_ram_en_pre", 64'(bus.ram_en), 64'd1);
        #2 rst = 1'b1;
        #1 check("abort_ram_en", 64'(bus.ram_en), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_rdata", {bus.if_rdata, bus.ls_rdata[31:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rv = 0;
        repeat (4) begin
            @(negedge clk);
            rv += int'(bus.if_rvalid | bus.ls_rvalid);
        end
        check("abort_no_rvalid", 64'(rv), 64'd0);
        last_ls = '0; last_if = '0; ls_known = 1; if_known = 1;
        run_ref(0, 0, 2'd2, 64'h8110, 64'h0, be, rd, err);
        for (int k = 0; k < 200; k++) begin
            ls = $urandom_range(0, 3) != 0;
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if (!ls) addr[1:0] = 2'b00;
            else if ($urandom_range(0, 1) == 1) addr[2:0] = addr[2:0] & ~3'((1 << sz) - 1);
            run_ref(ls, we, sz, addr, {$urandom, $urandom}, be, rd, err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
